// File: rtl/cp0_exception_ctrl.sv
// CP0 hardware-side writer: picks one of exception / interrupt / ERET at the
// MEM commit point, strobes the CP0 updates, then flushes and redirects fetch.
module cp0_exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter int          NUM_IRQ    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pause,
  input  logic               inst_valid_i,
  input  logic               exc_valid_i,
  input  logic [4:0]         exc_code_i,
  input  logic [31:0]        exc_pc_i,
  input  logic               exc_in_delay_i,
  input  logic [31:0]        exc_badvaddr_i,
  input  logic               eret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [31:0]        cp0_status_i,
  input  logic [31:0]        cp0_cause_i,
  input  logic [31:0]        cp0_epc_i,
  output logic               cp0_status_wen_o,
  output logic               cp0_epc_wen_o,
  output logic               cp0_cause_wen_o,
  output logic               cp0_badvaddr_wen_o,
  output logic [31:0]        cp0_status_o,
  output logic [31:0]        cp0_epc_o,
  output logic [31:0]        cp0_cause_o,
  output logic [31:0]        cp0_badvaddr_o,
  output logic               flush_o,
  output logic               redirect_valid_o,
  output logic [31:0]        redirect_pc_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_REDIRECT} state_t;
  typedef enum logic [1:0] {K_NONE, K_EXC, K_INT, K_ERET} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d, sel;
  logic [31:0] epc_lat_q, epc_lat_d;

  logic        status_wen_q, status_wen_d;
  logic        epc_wen_q, epc_wen_d;
  logic        cause_wen_q, cause_wen_d;
  logic        badvaddr_wen_q, badvaddr_wen_d;
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        busy_q, busy_d;

  logic        int_pend;
  logic [5:0]  ip_field;
  logic [4:0]  code;

  always_comb begin
    int_pend = (|(irq_i & cp0_status_i[10 +: NUM_IRQ])) & cp0_status_i[0]
               & ~cp0_status_i[1] & inst_valid_i;
    ip_field = cp0_cause_i[15:10];
    ip_field[NUM_IRQ-1:0] = irq_i;
    code = exc_valid_i ? exc_code_i : 5'd0;

    if (exc_valid_i)   sel = K_EXC;
    else if (int_pend) sel = K_INT;
    else if (eret_i)   sel = K_ERET;
    else               sel = K_NONE;

    state_d          = state_q;
    kind_d           = kind_q;
    epc_lat_d        = epc_lat_q;
    status_wen_d     = 1'b0;
    epc_wen_d        = 1'b0;
    cause_wen_d      = 1'b0;
    badvaddr_wen_d   = 1'b0;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    status_d         = status_q;
    epc_d            = epc_q;
    cause_d          = cause_q;
    badvaddr_d       = badvaddr_q;
    redirect_pc_d    = redirect_pc_q;

    // Strobes are registered on the edge that enters the state they belong to,
    // so a paused edge simply registers zeros and holds the state.
    if (!pause) begin
      unique case (state_q)
        S_IDLE: begin
          if (sel != K_NONE) begin
            state_d      = S_COMMIT;
            kind_d       = sel;
            epc_lat_d    = cp0_epc_i;
            flush_d      = 1'b1;
            status_wen_d = 1'b1;
            if (sel == K_ERET) begin
              status_d = cp0_status_i & ~32'h0000_0002;
            end else begin
              status_d    = cp0_status_i | 32'h0000_0002;
              cause_wen_d = 1'b1;
              cause_d     = {exc_in_delay_i, cp0_cause_i[30:16], ip_field,
                             cp0_cause_i[9:7], code, 2'b00};
              epc_wen_d   = ~cp0_status_i[1];
              epc_d       = exc_in_delay_i ? exc_pc_i - 32'd4 : exc_pc_i;
              if (sel == K_EXC && (code == 5'd4 || code == 5'd5)) begin
                badvaddr_wen_d = 1'b1;
                badvaddr_d     = exc_badvaddr_i;
              end
            end
          end
        end
        S_COMMIT: begin
          state_d          = S_REDIRECT;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = (kind_q == K_ERET) ? epc_lat_q : EXC_VECTOR;
        end
        S_REDIRECT: begin
          state_d   = S_IDLE;
          kind_d    = K_NONE;
          epc_lat_d = 32'd0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      kind_q           <= K_NONE;
      epc_lat_q        <= 32'd0;
      status_wen_q     <= 1'b0;
      epc_wen_q        <= 1'b0;
      cause_wen_q      <= 1'b0;
      badvaddr_wen_q   <= 1'b0;
      status_q         <= 32'd0;
      epc_q            <= 32'd0;
      cause_q          <= 32'd0;
      badvaddr_q       <= 32'd0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      kind_q           <= kind_d;
      epc_lat_q        <= epc_lat_d;
      status_wen_q     <= status_wen_d;
      epc_wen_q        <= epc_wen_d;
      cause_wen_q      <= cause_wen_d;
      badvaddr_wen_q   <= badvaddr_wen_d;
      status_q         <= status_d;
      epc_q            <= epc_d;
      cause_q          <= cause_d;
      badvaddr_q       <= badvaddr_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
    end
  end

  assign cp0_status_wen_o   = status_wen_q;
  assign cp0_epc_wen_o      = epc_wen_q;
  assign cp0_cause_wen_o    = cause_wen_q;
  assign cp0_badvaddr_wen_o = badvaddr_wen_q;
  assign cp0_status_o       = status_q;
  assign cp0_epc_o          = epc_q;
  assign cp0_cause_o        = cause_q;
  assign cp0_badvaddr_o     = badvaddr_q;
  assign flush_o            = flush_q;
  assign redirect_valid_o   = redirect_valid_q;
  assign redirect_pc_o      = redirect_pc_q;
  assign busy_o             = busy_q;

endmodule
